// File: rtl/alu_pkg.sv
// Shared types for the alu_mc handshaked ALU: opcodes, FSM states, status flags.
// ALU_MC_MUL_EN adds the BUSY state used by the iterative multiply.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_XOR = 4'd3,
        OP_SUB = 4'd6,
        OP_SLT = 4'd7,
        OP_SLL = 4'd8,
        OP_SRL = 4'd9,
        OP_MUL = 4'd10
    } op_e;

`ifdef ALU_MC_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_e;
`endif

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative radix-2 shift-add unsigned multiplier, one partial product per cycle.
// The start cycle already performs the first step, so WIDTH steps end WIDTH-1 cycles after start.
module alu_mul_iter #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   step_mcand;
    logic [2*WIDTH-1:0] step_in;
    logic [WIDTH:0]     partial;

    // Product register holds {accumulator, remaining multiplier bits}; each step shifts right by one.
    always_comb begin
        step_mcand = (start && !busy_q) ? a : mcand_q;
        step_in    = (start && !busy_q) ? {{WIDTH{1'b0}}, b} : prod_q;
        partial    = {1'b0, step_in[2*WIDTH-1:WIDTH]}
                   + {1'b0, step_mcand & {WIDTH{step_in[0]}}};
    end

    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start && !busy_q) begin
            mcand_d = a;
            prod_d  = {partial, step_in[WIDTH-1:1]};
            cnt_d   = CW'(1);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            prod_d = {partial, step_in[WIDTH-1:1]};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU with registered result and flags.
// Define ALU_MC_MUL_EN to include the iterative multiplier (opcode 10); otherwise opcode 10 is illegal.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    flags_t           flags_q, flags_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flags;
    logic             alu_illegal;

`ifdef ALU_MC_MUL_EN
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (operand1),
        .b       (operand2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Extra top bit of sub_ext is the unsigned borrow.
    always_comb begin
        add_ext = {1'b0, operand1} + {1'b0, operand2};
        sub_ext = {1'b0, operand1} - {1'b0, operand2};
    end

    always_comb begin
        alu_res     = '0;
        alu_flags   = '0;
        alu_illegal = 1'b0;
        case (operation)
            OP_AND: alu_res = operand1 & operand2;
            OP_OR:  alu_res = operand1 | operand2;
            OP_XOR: alu_res = operand1 ^ operand2;
            OP_ADD: begin
                alu_res            = add_ext[WIDTH-1:0];
                alu_flags.carry    = add_ext[WIDTH];
                alu_flags.overflow = (operand1[WIDTH-1] == operand2[WIDTH-1])
                                  && (add_ext[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res            = sub_ext[WIDTH-1:0];
                alu_flags.carry    = sub_ext[WIDTH];
                alu_flags.overflow = (operand1[WIDTH-1] != operand2[WIDTH-1])
                                  && (sub_ext[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SLT: alu_res = WIDTH'($signed(operand1) < $signed(operand2));
            OP_SLL: alu_res = operand1 << operand2[SHW-1:0];
            OP_SRL: alu_res = operand1 >> operand2[SHW-1:0];
`ifdef ALU_MC_MUL_EN
            OP_MUL: alu_res = '0;
`endif
            default: alu_illegal = 1'b1;
        endcase
        // Illegal opcodes report every flag clear, including zero.
        alu_flags.zero     = !alu_illegal && (alu_res == '0);
        alu_flags.negative = alu_res[WIDTH-1];
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
`ifdef ALU_MC_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_MC_MUL_EN
                    if (operation == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = BUSY;
                    end else
`endif
                    begin
                        res_d     = alu_res;
                        flags_d   = alu_flags;
                        illegal_d = alu_illegal;
                        state_d   = DONE;
                    end
                end
            end
`ifdef ALU_MC_MUL_EN
            BUSY: begin
                if (mul_done && !mul_busy) begin
                    res_d            = mul_product[WIDTH-1:0];
                    flags_d.zero     = (mul_product[WIDTH-1:0] == '0);
                    flags_d.negative = mul_product[WIDTH-1];
                    flags_d.carry    = 1'b0;
                    flags_d.overflow = |mul_product[2*WIDTH-1:WIDTH];
                    illegal_d        = 1'b0;
                    state_d          = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            res_q     <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res       = res_q;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Table-driven scoreboard bench for alu_mc at WIDTH=8, plus backpressure and mid-operation reset sequences.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic [3:0]   operation;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;
    logic         illegal;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .operation (operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [3:0]   f;    // {zero, negative, carry, overflow}
        logic         ill;
        int           lat;  // edges from the accept edge to out_valid, accept edge counted
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] r, input logic [3:0] f, input logic ill,
                                input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.r = r; v.f = f; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input int lat);
        vec_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_res"}, res, e.r);
        chk({tag, "_flags"}, {zero, negative, carry, overflow}, e.f);
        chk({tag, "_illegal"}, illegal, e.ill);
        if (lat >= 0) chk({tag, "_latency"}, lat, e.lat);
        $display("op=%0d a=%h b=%h -> res=%h zncv=%b ill=%b lat=%0d", e.op, e.a, e.b, res,
                 {zero, negative, carry, overflow}, illegal, lat);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        operation = v.op;
        operand1  = v.a;
        operand2  = v.b;
        out_ready = 1'b1;
        chk($sformatf("v%0d_in_ready", idx), in_ready, 1);
        sb.push_back(v);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                // request drops and operands wander; the captured values must be used
                in_valid  = 1'b0;
                operand1  = W'($urandom);
                operand2  = W'($urandom);
                operation = 4'($urandom);
            end
        end while (!out_valid && lat < 64);
        if (!out_valid) begin
            chk($sformatf("v%0d_timeout", idx), 0, 1);
            void'(sb.pop_front());
        end else begin
            chk($sformatf("v%0d_in_ready_busy", idx), in_ready, 0);
            check_result($sformatf("v%0d", idx), lat);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_release", idx), out_valid, 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        operand1  = '0;
        operand2  = '0;
        operation = '0;
        out_ready = 1'b0;

        vecs.push_back(mk(OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101, 1'b0, 1));
        vecs.push_back(mk(OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010, 1'b0, 1));
        vecs.push_back(mk(OP_SUB, 8'h05, 8'h05, 8'h00, 4'b1000, 1'b0, 1));
        vecs.push_back(mk(OP_SUB, 8'h03, 8'h05, 8'hFE, 4'b0110, 1'b0, 1));
        vecs.push_back(mk(OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0001, 1'b0, 1));
        vecs.push_back(mk(OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0, 1));
        vecs.push_back(mk(OP_OR,  8'hF0, 8'h0F, 8'hFF, 4'b0100, 1'b0, 1));
        vecs.push_back(mk(OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b1000, 1'b0, 1));
        vecs.push_back(mk(OP_SLT, 8'hFF, 8'h01, 8'h01, 4'b0000, 1'b0, 1));
        vecs.push_back(mk(OP_SLT, 8'h01, 8'hFF, 8'h00, 4'b1000, 1'b0, 1));
        vecs.push_back(mk(OP_SLL, 8'h01, 8'h0B, 8'h08, 4'b0000, 1'b0, 1));
        vecs.push_back(mk(OP_SRL, 8'h80, 8'h0F, 8'h01, 4'b0000, 1'b0, 1));
        vecs.push_back(mk(4'd5,   8'h12, 8'h34, 8'h00, 4'b0000, 1'b1, 1));
        vecs.push_back(mk(4'd15,  8'h00, 8'h00, 8'h00, 4'b0000, 1'b1, 1));
`ifdef ALU_MC_MUL_EN
        vecs.push_back(mk(OP_MUL, 8'h10, 8'h10, 8'h00, 4'b1001, 1'b0, W + 1));
        vecs.push_back(mk(OP_MUL, 8'h0C, 8'h0B, 8'h84, 4'b0100, 1'b0, W + 1));
        vecs.push_back(mk(OP_MUL, 8'hFF, 8'hFF, 8'h01, 4'b0001, 1'b0, W + 1));
`else
        vecs.push_back(mk(OP_MUL, 8'h10, 8'h10, 8'h00, 4'b0000, 1'b1, 1));
        vecs.push_back(mk(OP_MUL, 8'h0C, 8'h0B, 8'h00, 4'b0000, 1'b1, 1));
`endif

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_flags", {zero, negative, carry, overflow, illegal}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // backpressure: result held 5 cycles, a waiting second request stays out
        @(negedge clk);
        in_valid  = 1'b1;
        operation = OP_ADD;
        operand1  = 8'h12;
        operand2  = 8'h34;
        out_ready = 1'b0;
        sb.push_back(mk(OP_ADD, 8'h12, 8'h34, 8'h46, 4'b0000, 1'b0, 1));
        @(posedge clk);
        #1;
        operation = OP_SUB;
        operand1  = 8'h50;
        operand2  = 8'h10;
        chk("bp_first_valid", out_valid, 1);
        check_result("bp_add", -1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_valid", c), out_valid, 1);
            chk($sformatf("bp_hold%0d_res", c), res, 8'h46);
            chk($sformatf("bp_hold%0d_flags", c), {zero, negative, carry, overflow}, 4'b0000);
            chk($sformatf("bp_hold%0d_in_ready", c), in_ready, 0);
        end
        sb.push_back(mk(OP_SUB, 8'h50, 8'h10, 8'h40, 4'b0000, 1'b0, 1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_handshake_valid", out_valid, 0);
        chk("bp_handshake_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_valid", out_valid, 1);
        check_result("bp_sub", -1);
        @(posedge clk);
        #1;
        chk("bp_second_release", out_valid, 0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        in_valid  = 1'b1;
`ifdef ALU_MC_MUL_EN
        operation = OP_MUL;
        operand1  = 8'h0C;
        operand2  = 8'h0B;
        out_ready = 1'b1;
`else
        operation = OP_ADD;
        operand1  = 8'h7F;
        operand2  = 8'h01;
        out_ready = 1'b0;
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
`ifdef ALU_MC_MUL_EN
        chk("mrst_busy_valid", out_valid, 0);
        chk("mrst_busy_in_ready", in_ready, 0);
`else
        chk("mrst_done_valid", out_valid, 1);
`endif
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_res", res, 0);
        chk("mrst_flags", {zero, negative, carry, overflow, illegal}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_in_ready", in_ready, 1);
        run_vec(mk(OP_ADD, 8'h21, 8'h12, 8'h33, 4'b0000, 1'b0, 1), 100);
        // no stale multiply result may surface afterwards
        repeat (W + 2) @(posedge clk);
        #1;
        chk("mrst_no_stale_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, handshaked, parametrised ALU: the next-generation datapath ALU for the lab processor core. It accepts one operation per transaction on a valid/ready input port and returns a registered result with zero/negative/carry/overflow flags on a valid/ready output port. It extends the single-cycle AND/OR/ADD/SUB set with XOR, signed compare, shifts and an iterative multiply. It sits between the register-read stage and write-back, and the execute-stage controller stalls on the ready signals.

## Interface
- WIDTH, 64: operand/result width, ≥ 4, power of two.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  ALU can accept a request.
- operand1, operand2  in  WIDTH each  source operands.
- operation  in  4  opcode.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- res  out  WIDTH  result.
- zero, negative, carry, overflow  out  1 each  status flags.
- illegal  out  1  opcode not supported.

## Operation
- Opcodes: 0 AND, 1 OR, 2 ADD, 3 XOR, 6 SUB, 7 SLT (signed, res = 1 or 0), 8 SLL, 9 SRL (logical), 10 MUL (low WIDTH bits, unsigned).
- Shifts use operand2[$clog2(WIDTH)-1:0]. Upper bits are ignored.
- All other opcodes: res = 0, illegal = 1, other flags 0, latency as single-cycle.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. On in_valid, operands and opcode are captured. A non-MUL opcode computes the result, registers it and goes to DONE. MUL goes to BUSY.
  - BUSY: in_ready = 0. Radix-2 shift-add runs for exactly WIDTH cycles, then goes to DONE.
  - DONE: out_valid = 1. res and flags are held stable until out_valid && out_ready, then the FSM returns to IDLE. in_ready = 0.
- Flags (registered with res):
  - zero = (res == 0).
  - negative = res[WIDTH-1].
  - ADD: carry = carry-out; overflow = signed overflow.
  - SUB: carry = borrow (operand1 < operand2 unsigned); overflow = signed overflow.
  - MUL: carry = 0; overflow = 1 if the full 2·WIDTH product has any nonzero upper-half bit.
  - All other ops: carry = overflow = 0.
- Operand and opcode changes while not in IDLE are ignored.

## Timing
- Reset (asynchronous, at any state including mid-BUSY): state IDLE, res = 0, all flags 0, illegal 0, out_valid 0. The multiply in progress is discarded. in_ready = 1 after reset deasserts.
- Single-cycle ops: accepted at edge N, out_valid high after edge N+1 (latency 1).
- MUL: accepted at edge N, out_valid high after edge N+WIDTH+1.
- out_valid with out_ready already high completes in one cycle. Peak throughput is one op per 2 cycles.
- out_ready low while out_valid: hold indefinitely, with no changes to res or flags.

## Configuration
- ALU_MC_MUL_EN defined: MUL supported as above.
- ALU_MC_MUL_EN undefined: no multiplier logic and no BUSY state. Opcode 10 is treated as illegal (res 0, illegal 1, latency 1).

## Structure
- Package alu_pkg: opcode localparams/enum (OP_AND … OP_MUL), FSM state typedef, and a flag-struct typedef.
- Sub-module alu_mul_iter: iterative unsigned multiplier. Ports: start, a, b, busy, done, product[2·WIDTH-1:0]. Instantiated only under ALU_MC_MUL_EN.

## Test plan
- WIDTH=8, ADD 0x7F+0x01 -> res 0x80, overflow 1, negative 1, carry 0, zero 0, out_valid 1 cycle after accept.
- WIDTH=8, SUB 0x05−0x05 -> res 0x00, zero 1, carry 0. SUB 0x03−0x05 -> res 0xFE, carry 1, negative 1.
- WIDTH=8, MUL 0x10×0x10 -> res 0x00, overflow 1, zero 1, out_valid exactly 9 cycles after accept. MUL 0x0C×0x0B -> res 0x84, overflow 0.
- Opcode 5 -> res 0, illegal 1. SLT 0xFF vs 0x01 -> res 1. SRL 0x80 by 0x0F (uses 3 bits = 7) -> res 0x01.
- Backpressure: hold out_ready low 5 cycles -> res/flags/out_valid stable, in_ready 0, second request not accepted until handshake completes.
- Assert rst mid-MUL (cycle 4 of BUSY) -> immediate out_valid 0, res 0, and a following ADD completes normally.
- Build without ALU_MC_MUL_EN -> opcode 10 gives illegal 1, latency 1.
